// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream instruction memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);
    localparam int unsigned CSUM_W         = 8;

endpackage

// File: rtl/strobe_sync_edge.sv
// Synchronizes the asynchronous host strobe and emits a one-cycle pulse per rising edge.
module strobe_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_pulse_c
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_pulse_c = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/byte_word_loader.sv
// Loads a checksummed byte frame as little-endian words into instruction memory
// and holds the CPU in reset until a frame has been verified.
module byte_word_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_en,
    input  logic              i_byte_strobe,
    input  logic [7:0]        i_byte_data,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_cpu_rst_n,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W:0]   o_words_loaded
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t                          r_state;
    logic                            r_load_en_d;
    logic [IDX_W-1:0]                r_byte_idx;
    logic [CSUM_W-1:0]               r_csum;
    logic [BYTES_PER_WORD-2:0][7:0]  r_word;
    logic [CNT_W-1:0]                r_count;

    logic w_accept;
    logic w_arm;
    logic w_active;
    logic w_last_word;
    logic w_last_lane;

    strobe_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_strobe (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_async   (i_byte_strobe),
        .o_pulse_c (w_accept)
    );

    assign w_arm       = i_load_en & ~r_load_en_d;
    assign w_active    = (r_state == COUNT) || (r_state == DATA) || (r_state == CHECK);
    assign w_last_word = (CNT_W'(o_words_loaded + CNT_W'(1)) == r_count);
    assign w_last_lane = (r_byte_idx == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_load_en_d    <= 1'b0;
            r_byte_idx     <= '0;
            r_csum         <= '0;
            r_word         <= '0;
            r_count        <= '0;
            o_mem_we       <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_wdata    <= '0;
            o_cpu_rst_n    <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_err          <= 1'b0;
            o_words_loaded <= '0;
        end else begin
            r_load_en_d <= i_load_en;
            o_cpu_rst_n <= o_done & ~i_load_en;
            o_mem_we    <= 1'b0;

            // Post-write bookkeeping; the address stays on the last word rather than wrapping.
            if (o_mem_we) begin
                o_words_loaded <= CNT_W'(o_words_loaded + CNT_W'(1));
                if (!w_last_word) begin
                    o_mem_addr <= ADDR_W'(o_mem_addr + ADDR_W'(1));
                end
            end

            if (w_active && !i_load_en) begin
                r_state <= IDLE;
                o_busy  <= 1'b0;
                o_done  <= 1'b0;
                o_err   <= 1'b1;
            end else if (w_arm) begin
                r_state        <= COUNT;
                o_busy         <= 1'b1;
                o_done         <= 1'b0;
                o_err          <= 1'b0;
                o_words_loaded <= '0;
                r_csum         <= '0;
            end else begin
                case (r_state)
                    COUNT: begin
                        if (w_accept) begin
                            if (i_byte_data == 8'd0 || 32'(i_byte_data) > DEPTH) begin
                                r_state <= ERROR;
                                o_busy  <= 1'b0;
                                o_err   <= 1'b1;
                            end else begin
                                r_count    <= CNT_W'(i_byte_data);
                                o_mem_addr <= '0;
                                r_byte_idx <= '0;
                                r_state    <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (o_mem_we && w_last_word) begin
                            r_state <= CHECK;
                        end else if (w_accept) begin
                            r_csum     <= r_csum ^ i_byte_data;
                            r_byte_idx <= IDX_W'(r_byte_idx + IDX_W'(1));
                            if (w_last_lane) begin
                                o_mem_wdata <= {i_byte_data, r_word[2], r_word[1], r_word[0]};
                                o_mem_we    <= 1'b1;
                            end else begin
                                r_word[r_byte_idx] <= i_byte_data;
                            end
                        end
                    end
                    CHECK: begin
                        if (w_accept) begin
                            o_busy <= 1'b0;
                            if (i_byte_data == r_csum) begin
                                r_state <= DONE;
                                o_done  <= 1'b1;
                            end else begin
                                r_state <= ERROR;
                                o_err   <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_byte_word_loader.sv
// Directed self-checking bench for byte_word_loader.
module tb_byte_word_loader;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_en;
    logic              strobe;
    logic [7:0]        bdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int total = 0;
    int bad   = 0;

    int                wr_count = 0;
    logic [ADDR_W-1:0] wr_addr [64];
    logic [31:0]       wr_data [64];

    byte_word_loader #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_load_en      (load_en),
        .i_byte_strobe  (strobe),
        .i_byte_data    (bdata),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_cpu_rst_n    (cpu_rst_n),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err),
        .o_words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Record every memory write pulse seen on the port.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_count < 64) begin
                wr_addr[wr_count] = mem_addr;
                wr_data[wr_count] = mem_wdata;
            end
            wr_count = wr_count + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        bdata  = b;
        strobe = 1'b1;
        repeat (hold) @(negedge clk);
        strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic arm();
        @(negedge clk);
        load_en  = 1'b0;
        wr_count = 0;
        @(negedge clk);
        load_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_en = 1'b0; strobe = 1'b0; bdata = 8'h00;
        repeat (3) @(negedge clk);
        total++; if (mem_we !== 1'b0)       begin bad++; $display("FAIL reset_we got=%b want=0", mem_we); end
        total++; if (mem_addr !== '0)       begin bad++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
        total++; if (mem_wdata !== 32'h0)   begin bad++; $display("FAIL reset_wdata got=%h want=0", mem_wdata); end
        total++; if (cpu_rst_n !== 1'b0)    begin bad++; $display("FAIL reset_cpu_rst_n got=%b want=0", cpu_rst_n); end
        total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, err}); end
        total++; if (words_loaded !== '0)   begin bad++; $display("FAIL reset_words got=%0d want=0", words_loaded); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_word();
        arm();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
        send_byte(8'h01, 4); send_byte(8'h78, 4); send_byte(8'h56, 4);
        send_byte(8'h34, 4); send_byte(8'h12, 4); send_byte(8'h08, 4);
        total++; if (wr_count !== 1) begin bad++; $display("FAIL single_wr_count got=%0d want=1", wr_count); end
        total++; if (wr_addr[0] !== 5'd0) begin bad++; $display("FAIL single_addr got=%h want=0", wr_addr[0]); end
        total++; if (wr_data[0] !== 32'h12345678) begin bad++; $display("FAIL single_data got=%h want=12345678", wr_data[0]); end
        total++; if ({done, err, busy} !== 3'b100) begin bad++; $display("FAIL single_flags got=%b want=100", {done, err, busy}); end
        total++; if (words_loaded !== 6'd1) begin bad++; $display("FAIL single_words got=%0d want=1", words_loaded); end
        total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL single_cpu_held got=%b want=0", cpu_rst_n); end
        load_en = 1'b0;
        @(negedge clk);
        total++; if (cpu_rst_n !== 1'b1) begin bad++; $display("FAIL single_cpu_release got=%b want=1", cpu_rst_n); end
    endtask

    task automatic test_bad_checksum();
        arm();
        total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL badck_arm_cpu got=%b want=0", cpu_rst_n); end
        send_byte(8'h01, 4); send_byte(8'h78, 4); send_byte(8'h56, 4);
        send_byte(8'h34, 4); send_byte(8'h12, 4); send_byte(8'h09, 4);
        total++; if ({done, err} !== 2'b01) begin bad++; $display("FAIL badck_flags got=%b want=01", {done, err}); end
        total++; if (wr_count !== 1 || wr_data[0] !== 32'h12345678 || wr_addr[0] !== 5'd0)
            begin bad++; $display("FAIL badck_write got=%0d/%h/%h want=1/12345678/00", wr_count, wr_data[0], wr_addr[0]); end
        load_en = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL badck_cpu got=%b want=0", cpu_rst_n); end
    endtask

    task automatic test_count_bounds();
        arm();
        send_byte(8'h00, 4);
        total++; if ({err, busy, done} !== 3'b100 || wr_count !== 0)
            begin bad++; $display("FAIL n0 got=%b/%0d want=100/0", {err, busy, done}, wr_count); end
        arm();
        send_byte(8'h21, 4);
        total++; if ({err, busy, done} !== 3'b100) begin bad++; $display("FAIL n33 got=%b want=100", {err, busy, done}); end
    endtask

    task automatic test_full_frame();
        logic [7:0]  b;
        logic [7:0]  ck;
        logic [31:0] w;
        ck = 8'h00;
        arm();
        send_byte(8'h20, 4);
        for (int i = 0; i < 32; i++) begin
            for (int l = 0; l < 4; l++) begin
                b  = 8'(i * 4 + l) ^ 8'h5A;
                ck = ck ^ b;
                send_byte(b, 4);
            end
        end
        send_byte(ck, 4);
        total++; if (wr_count !== 32) begin bad++; $display("FAIL n32_count got=%0d want=32", wr_count); end
        for (int i = 0; i < 32; i++) begin
            for (int l = 0; l < 4; l++) w[l*8 +: 8] = 8'(i * 4 + l) ^ 8'h5A;
            total++;
            if (wr_addr[i] !== 5'(i) || wr_data[i] !== w) begin
                bad++; $display("FAIL n32_word%0d got=%h@%0d want=%h@%0d", i, wr_data[i], wr_addr[i], w, i);
            end
        end
        total++; if (words_loaded !== 6'd32) begin bad++; $display("FAIL n32_words got=%0d want=32", words_loaded); end
        total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL n32_flags got=%b want=10", {done, err}); end
    endtask

    task automatic test_abort();
        arm();
        send_byte(8'h01, 4); send_byte(8'hAA, 4); send_byte(8'hBB, 4);
        load_en = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({err, done, busy} !== 3'b100) begin bad++; $display("FAIL abort_flags got=%b want=100", {err, done, busy}); end
        total++; if (wr_count !== 0 || words_loaded !== '0)
            begin bad++; $display("FAIL abort_writes got=%0d/%0d want=0/0", wr_count, words_loaded); end
    endtask

    task automatic test_strobe_hold();
        arm();
        send_byte(8'h01, 10);
        send_byte(8'h11, 4); send_byte(8'h22, 4); send_byte(8'h33, 4);
        send_byte(8'h44, 4); send_byte(8'h44, 4);
        total++; if (wr_count !== 1 || wr_data[0] !== 32'h44332211)
            begin bad++; $display("FAIL hold_write got=%0d/%h want=1/44332211", wr_count, wr_data[0]); end
        total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL hold_flags got=%b want=10", {done, err}); end
    endtask

    task automatic test_same_cycle_arm();
        @(negedge clk);
        load_en = 1'b0;
        repeat (3) @(negedge clk);
        wr_count = 0;
        bdata  = 8'h05;
        strobe = 1'b1;
        repeat (2) @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        total++; if ({busy, err, done} !== 3'b100) begin bad++; $display("FAIL coinc_state got=%b want=100", {busy, err, done}); end
        strobe = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h01, 4); send_byte(8'h11, 4); send_byte(8'h22, 4);
        send_byte(8'h33, 4); send_byte(8'h44, 4); send_byte(8'h44, 4);
        total++; if (wr_count !== 1 || wr_data[0] !== 32'h44332211 || done !== 1'b1)
            begin bad++; $display("FAIL coinc_frame got=%0d/%h/%b want=1/44332211/1", wr_count, wr_data[0], done); end
    endtask

    task automatic test_reset_mid_write();
        arm();
        send_byte(8'h01, 4); send_byte(8'hAA, 4); send_byte(8'hBB, 4); send_byte(8'hCC, 4);
        @(negedge clk);
        bdata  = 8'hDD;
        strobe = 1'b1;
        repeat (2) @(negedge clk);
        rst_n   = 1'b0;
        load_en = 1'b0;
        @(negedge clk);
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rstmid_we got=%b want=0", mem_we); end
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        strobe = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (wr_count !== 0) begin bad++; $display("FAIL rstmid_writes got=%0d want=0", wr_count); end
        total++; if ({busy, done, err, cpu_rst_n} !== 4'b0000 || words_loaded !== '0 || mem_addr !== '0 || mem_wdata !== 32'h0)
            begin bad++; $display("FAIL rstmid_clear got=%b/%0d/%h/%h want=0000/0/0/0", {busy, done, err, cpu_rst_n}, words_loaded, mem_addr, mem_wdata); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_bad_checksum();
        test_count_bounds();
        test_full_frame();
        test_abort();
        test_strobe_hold();
        test_same_cycle_arm();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_word_loader.md
Name: byte_word_loader

Overview:
- Receive-side counterpart of the top-level word-to-byte output serializer.
- Accepts a host byte stream on dedicated pins, assembles little-endian 32-bit words and writes them sequentially into instruction memory.
- Holds the CPU in reset until a complete, checksum-verified frame has been loaded.
- Sits between the TT pin inputs and the instruction memory write port, alongside the `risc` core.

Parameters:
- DEPTH, 32, instruction memory depth in words; maximum word count per frame.
- ADDR_W, 5, memory address width; must satisfy 2^ADDR_W >= DEPTH.
- SYNC_STAGES, 2, flip-flop stages in the strobe synchronizer.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- load_en  in  1  loader mode; high holds CPU in reset; a rising edge arms a new frame.
- byte_strobe  in  1  asynchronous host strobe; each rising edge delivers one byte.
- byte_data  in  8  host byte; must be stable from strobe rise for SYNC_STAGES+2 cycles.
- mem_we  out  1  one-cycle instruction memory write pulse.
- mem_addr  out  ADDR_W  word write address.
- mem_wdata  out  32  assembled word.
- cpu_rst_n  out  1  registered CPU reset (active low).
- busy  out  1  frame in progress.
- done  out  1  last frame loaded and verified.
- err  out  1  last frame rejected.
- words_loaded  out  ADDR_W+1  words written in the current or last frame.

Behaviour:
- Reset (rst_n low at a clk edge) forces these values:
  - state IDLE; all synchronizer and edge flops 0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_rst_n=0, busy=0, done=0, err=0, words_loaded=0.
  - internal byte index=0, checksum=0.
- Strobe front end:
  - byte_strobe passes through SYNC_STAGES flops, then an edge register.
  - A byte is "accepted" in the single cycle where synced=1 and previous=0, i.e. SYNC_STAGES+1 cycles after the pin rises.
  - byte_data is sampled directly in the accept cycle.
  - Holding the strobe high yields exactly one accept.
- Frame format, in order:
  - count byte N.
  - 4*N data bytes, least significant byte first.
  - checksum byte equal to the XOR of all data bytes.
- States:
  - IDLE: busy=0. A rising edge of load_en (registered compare) moves to COUNT, clears done, err, words_loaded and checksum, and drives cpu_rst_n=0.
  - COUNT: on accept, N=0 or N>DEPTH goes to ERROR; otherwise latch N, set mem_addr=0, and go to DATA.
  - DATA:
    - On each accept, shift the byte into lane byte_index of the word register and XOR it into the checksum.
    - On the 4th byte: mem_wdata=word and mem_we=1 for exactly the next cycle, at the current mem_addr.
    - The cycle after the write, mem_addr increments and words_loaded increments.
    - When words_loaded reaches N, go to CHECK.
    - mem_addr never wraps within a frame because N<=DEPTH.
  - CHECK: on accept, byte==checksum goes to DONE; otherwise go to ERROR.
  - DONE: done=1, busy=0. Remains until the next load_en rising edge.
  - ERROR: err=1, busy=0. Words already written are not rolled back. Remains until the next load_en rising edge.
- busy=1 exactly in COUNT, DATA and CHECK.
- cpu_rst_n is registered: next value = done AND NOT load_en. A new frame therefore drops it in the arm cycle.
- load_en falls while in COUNT, DATA or CHECK: abort to IDLE on the next cycle.
  - A pending mem_we still completes.
  - err=1, done=0; words_loaded holds the partial count.
- Accepts in IDLE, DONE or ERROR are ignored; they cause no write and no checksum change.
- Accept and load_en rising edge in the same cycle: the arm takes priority and the byte is dropped.
- rst_n low mid-frame: immediate return to reset values; any in-flight mem_we is suppressed.

Decomposition:
- Shared package `loader_pkg` holds:
  - state enum: IDLE, COUNT, DATA, CHECK, DONE, ERROR.
  - BYTES_PER_WORD=4 constant.
  - checksum width constant (8).
- One natural sub-module, `strobe_sync_edge`: SYNC_STAGES synchronizer plus rising-edge pulse generator.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles -> all outputs 0, cpu_rst_n=0, state IDLE.
- Single-word frame: load_en rise, then bytes 01,78,56,34,12,checksum 08 -> mem_we one cycle with mem_addr=0 and mem_wdata=32'h12345678.
  - Then done=1, words_loaded=1.
  - After load_en falls, cpu_rst_n=1 one cycle later.
- Bad checksum: same frame with checksum 09 -> err=1, done=0, cpu_rst_n stays 0, word at address 0 still written.
- Count bounds:
  - N=0 -> err=1 with no mem_we.
  - N=33 with DEPTH=32 -> err=1.
  - N=32 -> 32 writes at addresses 0..31, words_loaded=32, done=1.
- Mid-frame events:
  - load_en drops after 2 of 4 data bytes -> no write, err=1, IDLE.
  - rst_n pulsed during a DATA write cycle -> mem_we=0 and all state cleared.
- Strobe robustness:
  - strobe held high 10 cycles -> exactly one byte accepted.
  - strobe and load_en rise in the same accept cycle -> byte dropped, state COUNT.
